// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: I2C minion register bank with pointer byte, auto-increment and registered read prefetch.
// Optional per-register write strobes are built when I2C_REG_BANK_WSTROBE_EN is defined.
module i2c_reg_bank #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(1),
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int PW = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i2c_start,
  input  logic                       i2c_stop,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_req,
  output logic [DATA_W-1:0]          rd_data,
  input  logic [NUM_REGS*DATA_W-1:0] status_in,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [PW-1:0]              ptr,
  output logic                       err,
  input  logic                       err_clr,
  output logic [NUM_REGS-1:0]        wr_strobe
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PTR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_BAD  = 2'd3;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic err_q, err_d, err_set, wr_en, ptr_ok;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, rd_sel;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] hit;
  assign ptr_inc = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_ok = wr_data < DATA_W'(NUM_REGS);
  // stop beats start, and both swallow any coincident strobe
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    err_set = 1'b0;
    wr_en = 1'b0;
    if (i2c_stop) state_d = S_IDLE;
    else if (i2c_start) state_d = S_PTR;
    else case (state_q)
      S_IDLE: ptr_d = rd_req ? ptr_inc : ptr_q;
      S_PTR: begin
        if (wr_valid) begin
          ptr_d = ptr_ok ? wr_data[PW-1:0] : ptr_q;
          state_d = ptr_ok ? S_DATA : S_BAD;
          err_set = !ptr_ok;
        end else if (rd_req) begin
          ptr_d = ptr_inc;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        wr_en = wr_valid;
        ptr_d = (wr_valid || rd_req) ? ptr_inc : ptr_q;
      end
      default: ;
    endcase
  end
  assign err_d = err_set | (err_q & ~err_clr);
  always_comb begin
    hit = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = wr_en && ptr_q == PW'(i) && !RO_MASK[i];
      regs_d[i] = hit[i] ? wr_data : regs_q[i];
      if (ptr_q == PW'(i)) rd_sel = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs_q[i];
    end
  end
  assign rd_data_d = (state_q == S_BAD) ? '1 : rd_sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      err_q <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
  end
`ifdef I2C_REG_BANK_WSTROBE_EN
  logic [NUM_REGS-1:0] wr_strobe_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_strobe_q <= '0;
    else wr_strobe_q <= hit;
  end
  assign wr_strobe = wr_strobe_q;
`else
  assign wr_strobe = '0;
`endif
  assign rd_data = rd_data_q;
  assign ptr = ptr_q;
  assign err = err_q;
endmodule
